// File: rtl/ringbuf_stream.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ringbuf_stream: parametrised circular FIFO with valid/ready on each side |
// | Revision: 1.0                                                             |
// +-------------------------------------------------------------------------+
module ringbuf_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  outstrobe,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  overflow
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH + 1)'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  outstrobe_q, outstrobe_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop;

  // Handshake outputs depend on registered occupancy only, never on in_valid/out_ready.
  assign in_ready    = (level_q != C_DEPTH);
  assign out_valid   = (level_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign almost_full = (level_q >= C_AF);
  assign overflow    = overflow_q;
  assign outstrobe   = outstrobe_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    outstrobe_d = 1'b0;
    overflow_d  = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
        outstrobe_d = 1'b1;
      end
      if (in_valid && !in_ready) overflow_d = 1'b1;
      if (push && !pop) begin
        level_d = level_q + (ADDR_WIDTH + 1)'(1);
      end else if (pop && !push) begin
        level_d = level_q - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      outstrobe_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      outstrobe_q <= outstrobe_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is deliberately left unreset; contents are meaningless while empty.
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_ringbuf_stream.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ringbuf_stream: directed self-checking bench for ringbuf_stream       |
// | Revision: 1.0                                                             |
// +-------------------------------------------------------------------------+
module tb_ringbuf_stream;

  logic       clock;
  logic       reset;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       outstrobe;
  logic [2:0] level;
  logic       almost_full;
  logic       overflow;

  int n_cmp = 0;
  int n_mis = 0;

  ringbuf_stream #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outstrobe  (outstrobe),
    .level      (level),
    .almost_full(almost_full),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    drain_exp[0] = 8'h11; drain_exp[1] = 8'h22; drain_exp[2] = 8'h33; drain_exp[3] = 8'h44;
    reset = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_strobe", outstrobe, 0);
    #9 reset = 1'b0;

    // Fill to full, then attempt a write while full.
    in_valid = 1'b1; in_data = 8'h11; step();
    check("fill1_level", level, 1);
    check("fill1_out_valid", out_valid, 1);
    check("fill1_out_data", out_data, 8'h11);
    in_data = 8'h22; step();
    check("fill2_level", level, 2);
    check("fill2_af", almost_full, 0);
    in_data = 8'h33; step();
    check("fill3_level", level, 3);
    check("fill3_af", almost_full, 1);
    check("fill3_out_data", out_data, 8'h11);
    in_data = 8'h44; step();
    check("fill4_level", level, 4);
    check("fill4_in_ready", in_ready, 0);
    check("fill4_ovf", overflow, 0);
    in_data = 8'h55; step();
    check("ovf_set", overflow, 1);
    check("ovf_level", level, 4);
    in_valid = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", out_data, drain_exp[i]);
      step();
      check("drain_strobe", outstrobe, 1);
      check("drain_level", level, 3 - i);
    end
    check("drain_empty", out_valid, 0);
    step();
    check("empty_no_strobe", outstrobe, 0);
    check("empty_level", level, 0);
    check("ovf_sticky", overflow, 1);

    // Continuous streaming across two pointer wraps.
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 8'(k);
      step();
      check("wrap_data", out_data, k);
      check("wrap_level", level, 1);
    end
    in_valid = 1'b0;
    step();
    check("wrap_last_strobe", outstrobe, 1);
    check("wrap_final_level", level, 0);
    out_ready = 1'b0;

    // Simultaneous push and pop at level 2.
    in_valid = 1'b1; in_data = 8'hA0; step();
    in_data = 8'hA1; step();
    check("pp_pre_level", level, 2);
    in_data = 8'hA2; out_ready = 1'b1;
    check("pp_pre_data", out_data, 8'hA0);
    step();
    check("pp_level", level, 2);
    check("pp_data", out_data, 8'hA1);
    check("pp_strobe", outstrobe, 1);
    in_valid = 1'b0; out_ready = 1'b0; step();
    check("pp_strobe_off", outstrobe, 0);

    // Build level 3 with overflow set, then flush with push and pop asserted.
    in_valid = 1'b1; in_data = 8'hB3; step();
    in_data = 8'hB4; step();
    in_data = 8'hB5; step();
    check("pre_flush_ovf", overflow, 1);
    in_valid = 1'b0; out_ready = 1'b1; step();
    check("pre_flush_level", level, 3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    #1 check("flush_in_ready", in_ready, 1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_level", level, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_ovf", overflow, 0);
    check("flush_strobe", outstrobe, 0);
    in_valid = 1'b1; in_data = 8'h77; step();
    in_valid = 1'b0;
    check("post_flush_data", out_data, 8'h77);
    check("post_flush_level", level, 1);

    // Asynchronous reset between edges at level 2.
    in_valid = 1'b1; in_data = 8'h88; step();
    in_valid = 1'b0;
    check("pre_areset_level", level, 2);
    #2 reset = 1'b1;
    #1;
    check("areset_level", level, 0);
    check("areset_in_ready", in_ready, 1);
    check("areset_out_valid", out_valid, 0);
    #3 reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; step();
    in_valid = 1'b0;
    check("post_reset_data", out_data, 8'h5A);
    check("post_reset_level", level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ringbuf_stream.md
Name: ringbuf_stream

Overview:
- Parametrised successor to the fixed-size serial ring buffer. Stores DATA_WIDTH-bit words in a 2**ADDR_WIDTH-entry circular buffer.
- Decoupled valid/ready handshakes on both sides, plus occupancy, almost-full, sticky overflow, flush and a per-pop output strobe.
- Sits between a producer (e.g. serial deserialiser) and a consumer (retrieve/transmit stage) in the ringbuf datapath.

Parameters:
- DATA_WIDTH, 8, width of each stored word (>=1).
- ADDR_WIDTH, 2, pointer width; depth DEPTH = 2**ADDR_WIDTH (>=1).
- AF_LEVEL, 3, almost_full asserts when level >= AF_LEVEL (1..DEPTH).

Ports:
- clock  input  1  rising-edge clock, sole clock domain.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of buffer contents and flags.
- in_data  input  DATA_WIDTH  write word.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  buffer can accept a word (= not full).
- out_data  output  DATA_WIDTH  word at read pointer.
- out_valid  output  1  out_data is valid (= not empty).
- out_ready  input  1  consumer accepts out_data.
- outstrobe  output  1  registered one-cycle pulse, the cycle after each pop.
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- almost_full  output  1  level >= AF_LEVEL.
- overflow  output  1  sticky: write attempted while full.

Behaviour:
- Reset (async assert, sync release): wr_ptr = rd_ptr = 0, level = 0, outstrobe = 0, overflow = 0. Hence in_ready = 1, out_valid = 0, almost_full = 0. out_data is don't-care while out_valid = 0. Storage array is not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated at the rising clock edge.
- Push: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 modulo DEPTH (natural wrap of ADDR_WIDTH bits).
- Pop: rd_ptr <= rd_ptr+1 modulo DEPTH; outstrobe <= 1 next cycle, else 0.
- out_data = mem[rd_ptr], combinational read. out_valid = (level != 0). in_ready = (level != DEPTH). All three are derived from registered state only; no combinational path from in_valid/out_ready to any output.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N, i.e. in cycle N+1. Order is strictly FIFO.
- Level update: push only +1; pop only -1; push and pop together, no change; width ADDR_WIDTH+1, never exceeds DEPTH or goes below 0.
- Full (level = DEPTH):
  - in_ready = 0, even if a pop occurs in the same cycle. There is no write-through on full.
  - in_valid = 1 while full sets overflow; the word is dropped and pointers are unchanged.
- Empty (level = 0): out_valid = 0. out_ready is ignored; no pointer change and no outstrobe.
- Simultaneous push/pop at 0 < level < DEPTH: both pointers advance, level unchanged, outstrobe pulses.
- overflow stays set until reset or flush.
- flush = 1:
  - Next edge: pointers = 0, level = 0, overflow = 0, outstrobe = 0.
  - flush has priority; any push/pop in the same cycle is discarded.
  - in_ready stays 1 during flush cycles unless full beforehand.
- Reset mid-operation: immediate asynchronous return to reset values; all buffered data is lost.
- Producer must hold in_data/in_valid until in_ready; consumer sees out_data stable while out_valid = 1 and no pop occurs.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on consecutive cycles with out_ready = 0 -> level 1,2,3; almost_full = 1 at level 3; out_data = 0x11, out_valid = 1.
- Push a 4th word 0x44 -> level = 4, in_ready = 0. Hold in_valid = 1 with 0x55 -> overflow = 1, level stays 4. Drain: 0x11,0x22,0x33,0x44 in order with four outstrobe pulses, each one cycle after its pop; 0x55 never appears.
- Wrap-around: stream 10 words 0x00..0x09 with in_valid = out_ready = 1 continuously -> outputs 0x00..0x09 in order, level never exceeds 1; pointers wrap twice.
- Simultaneous push/pop at level 2 (contents 0xA0,0xA1; push 0xA2) -> level stays 2, out_data changes to 0xA1, outstrobe = 1 next cycle.
- Flush at level 3 with overflow = 1, with push and pop asserted the same cycle -> next cycle level = 0, out_valid = 0, overflow = 0, no outstrobe; the next push 0x77 appears at out_data one cycle later.
- Assert reset asynchronously mid-stream at level 2 between clock edges -> outputs return to reset values immediately (in_ready = 1, out_valid = 0, level = 0) before the next edge.
